// File: rtl/lm70_spi_scheduler.sv
// LM70 SPI read sequencer: arbitrates periodic auto-tick and manual trigger reads onto
// one SPI bus and presents the frame MSBs as a registered sample.
module lm70_spi_scheduler #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned PERIOD     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 auto_en,
  input  logic                 trig_req,
  input  logic                 miso,
  output logic                 cs_n,
  output logic                 sck,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_src,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned CS_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CNT_MAX = (2 * CLK_DIV > CS_MAX) ? 2 * CLK_DIV : CS_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int unsigned PER_W   = $clog2(PERIOD);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LIM   = BIT_W'(DATA_BITS);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [PER_W-1:0]     per_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend_man;
  logic                 pend_auto;
  logic                 auto_tick;
  logic                 req_any;

  always_comb begin
    auto_tick = en && auto_en && (per_cnt == PER_LAST);
    req_any   = pend_man || pend_auto || trig_req || auto_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!(en && auto_en) || per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      pend_man     <= 1'b0;
      pend_auto    <= 1'b0;
      cs_n         <= 1'b1;
      sck          <= 1'b0;
      sample       <= '0;
      sample_src   <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else if (!en) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      pend_man     <= 1'b0;
      pend_auto    <= 1'b0;
      cs_n         <= 1'b1;
      sck          <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      if (state == IDLE) begin
        if (req_any) begin
          // every request seen here, pending or fresh, is served by this one read
          state      <= SETUP;
          busy       <= 1'b1;
          cs_n       <= 1'b0;
          cnt        <= '0;
          bit_cnt    <= '0;
          sample_src <= pend_man || trig_req;
          pend_man   <= 1'b0;
          pend_auto  <= 1'b0;
        end
      end else begin
        if ((trig_req || auto_tick) && (pend_man || pend_auto)) begin
          overrun <= 1'b1;
        end else begin
          if (trig_req)  pend_man  <= 1'b1;
          if (auto_tick) pend_auto <= 1'b1;
        end
        case (state)
          SETUP: begin
            if (cnt == SETUP_LAST) begin
              state <= SHIFT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SHIFT: begin
            if (cnt == LOW_LAST) begin
              sck <= 1'b1;
              // only the leading DATA_BITS are kept, so later bits are not shifted in
              if (bit_cnt < DATA_LIM) shreg <= (shreg << 1) | DATA_BITS'(miso);
              cnt <= cnt + CNT_W'(1);
            end else if (cnt == BIT_LAST) begin
              sck     <= 1'b0;
              cnt     <= '0;
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (bit_cnt == FRAME_LAST) state <= HOLD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              state        <= DONE;
              cs_n         <= 1'b1;
              sample       <= shreg;
              sample_valid <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            cs_n  <= 1'b1;
            sck   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lm70_spi_scheduler.sv
// Directed self-checking bench for lm70_spi_scheduler with a behavioural LM70 miso model.
module tb_lm70_spi_scheduler;

  localparam int CLK_DIV = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       auto_en;
  logic       trig_req;
  logic       miso;
  logic       cs_n;
  logic       sck;
  logic [7:0] sample;
  logic       sample_src;
  logic       sample_valid;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          valid_total = 0;
  int          ovr_total = 0;
  logic [15:0] frame_word = 16'h0000;
  int          bit_idx = 0;

  int          cap_found, cap_low, cap_pulses, cap_bad_high, cap_first_rise;
  int          cap_start, cap_end;
  logic        cap_valid, cap_src;
  logic [7:0]  cap_sample;

  lm70_spi_scheduler #(
    .CLK_DIV(2), .FRAME_BITS(16), .DATA_BITS(8),
    .CS_SETUP(2), .CS_HOLD(2), .PERIOD(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .auto_en(auto_en), .trig_req(trig_req),
    .miso(miso), .cs_n(cs_n), .sck(sck), .sample(sample), .sample_src(sample_src),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (sample_valid === 1'b1) valid_total++;
    if (overrun === 1'b1) ovr_total++;
  end

  // Sensor model: MSB presented at cs_n fall, next bit after each sck rise
  always @(negedge cs_n) bit_idx = 0;
  always @(posedge sck) bit_idx = bit_idx + 1;
  assign miso = (bit_idx < 16) ? frame_word[15 - bit_idx] : 1'b0;

  task automatic capture(input int budget);
    int   n;
    int   run;
    logic prev_sck;
    cap_found = 0; cap_low = 0; cap_pulses = 0; cap_bad_high = 0; cap_first_rise = -1;
    n = 0;
    while (cs_n !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cs_n !== 1'b0) return;
    cap_found = 1;
    cap_start = cyc;
    prev_sck  = 1'b0;
    run       = 0;
    while (cs_n === 1'b0 && cap_low < 200) begin
      if (sck === 1'b1) begin
        if (prev_sck !== 1'b1) begin
          cap_pulses++;
          if (cap_first_rise < 0) cap_first_rise = cap_low;
        end
        run++;
      end else begin
        if (prev_sck === 1'b1 && run != CLK_DIV) cap_bad_high++;
        run = 0;
      end
      prev_sck = sck;
      cap_low++;
      @(negedge clk);
    end
    if (prev_sck === 1'b1 || sck !== 1'b0) cap_bad_high++;
    cap_end    = cyc;
    cap_valid  = sample_valid;
    cap_sample = sample;
    cap_src    = sample_src;
  endtask

  task automatic pulse_trig();
    @(negedge clk) trig_req = 1'b1;
    @(negedge clk) trig_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; auto_en = 1'b0; trig_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_n, sck, sample, sample_src, sample_valid, busy, overrun} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs: cs_n=%b sck=%b sample=%h src=%b valid=%b busy=%b ovr=%b, required cs_n=1 others 0",
               cs_n, sck, sample, sample_src, sample_valid, busy, overrun);
    end
    @(negedge clk) begin rst_n = 1'b1; en = 1'b1; end
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: cs_n=%b busy=%b, required 1/0", cs_n, busy);
    end
  endtask

  task automatic test_manual_read();
    int v0;
    frame_word = 16'h1A5F;
    v0 = valid_total;
    pulse_trig();
    capture(10);
    checks++;
    if (cap_found != 1) begin errors++; $display("FAIL t1_start: no cs_n fall within budget"); end
    checks++;
    if (cap_low != 68) begin errors++; $display("FAIL t1_cs_low: got %0d cycles, required 68", cap_low); end
    checks++;
    if (cap_pulses != 16 || cap_bad_high != 0) begin
      errors++; $display("FAIL t1_sck: pulses=%0d bad_high=%0d, required 16/0", cap_pulses, cap_bad_high);
    end
    checks++;
    if (cap_first_rise != 4) begin errors++; $display("FAIL t1_first_rise: got %0d, required 4", cap_first_rise); end
    checks++;
    if (cap_valid !== 1'b1 || cap_sample !== 8'h1A || cap_src !== 1'b1) begin
      errors++; $display("FAIL t1_sample: valid=%b sample=%h src=%b, required 1/1a/1", cap_valid, cap_sample, cap_src);
    end
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b0 || busy !== 1'b0 || valid_total - v0 != 1) begin
      errors++; $display("FAIL t1_valid_pulse: valid=%b busy=%b pulses=%0d, required 0/0/1",
                         sample_valid, busy, valid_total - v0);
    end
  endtask

  task automatic test_auto_period();
    int c0, o0, s1;
    frame_word = 16'hC3A0;
    o0 = ovr_total;
    @(negedge clk) auto_en = 1'b1;
    c0 = cyc;
    capture(1100);
    s1 = cap_start;
    checks++;
    if (cap_found != 1 || s1 - c0 != 1024) begin
      errors++; $display("FAIL t2_first_tick: found=%0d delay=%0d, required 1/1024", cap_found, s1 - c0);
    end
    checks++;
    if (cap_sample !== 8'hC3 || cap_src !== 1'b0 || cap_valid !== 1'b1) begin
      errors++; $display("FAIL t2_sample: sample=%h src=%b valid=%b, required c3/0/1", cap_sample, cap_src, cap_valid);
    end
    capture(1100);
    checks++;
    if (cap_found != 1 || cap_start - s1 != 1024 || cap_low != 68) begin
      errors++; $display("FAIL t2_period: found=%0d spacing=%0d low=%0d, required 1/1024/68",
                         cap_found, cap_start - s1, cap_low);
    end
    @(negedge clk) auto_en = 1'b0;
    checks++;
    if (ovr_total - o0 != 0) begin errors++; $display("FAIL t2_overrun: got %0d pulses, required 0", ovr_total - o0); end
  endtask

  task automatic test_merge();
    int c0, o0, v0;
    frame_word = 16'h96F0;
    repeat (3) @(negedge clk);
    o0 = ovr_total; v0 = valid_total;
    auto_en = 1'b1;
    c0 = cyc;
    repeat (1023) @(negedge clk);
    trig_req = 1'b1;
    @(negedge clk) begin trig_req = 1'b0; auto_en = 1'b0; end
    capture(5);
    checks++;
    if (cap_found != 1 || cap_start - c0 != 1024) begin
      errors++; $display("FAIL t3_start: found=%0d delay=%0d, required 1/1024", cap_found, cap_start - c0);
    end
    checks++;
    if (cap_sample !== 8'h96 || cap_src !== 1'b1) begin
      errors++; $display("FAIL t3_sample: sample=%h src=%b, required 96/1", cap_sample, cap_src);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (valid_total - v0 != 1 || ovr_total - o0 != 0 || cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL t3_single_read: reads=%0d overruns=%0d cs_n=%b busy=%b, required 1/0/1/0",
                         valid_total - v0, ovr_total - o0, cs_n, busy);
    end
  endtask

  task automatic test_back_to_back();
    int o0, n, end1;
    frame_word = 16'h3C00;
    o0 = ovr_total;
    pulse_trig();
    repeat (20) @(negedge clk);
    trig_req = 1'b1;
    @(negedge clk) trig_req = 1'b0;
    repeat (9) @(negedge clk);
    trig_req = 1'b1;
    @(negedge clk) trig_req = 1'b0;
    n = 0;
    while (cs_n !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    end1 = cyc;
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'h3C) begin
      errors++; $display("FAIL t4_first_read: valid=%b sample=%h, required 1/3c", sample_valid, sample);
    end
    frame_word = 16'h81FF;
    capture(10);
    checks++;
    if (cap_found != 1 || cap_start - end1 != 2) begin
      errors++; $display("FAIL t4_gap: found=%0d cs_n high=%0d cycles, required 1/2", cap_found, cap_start - end1);
    end
    checks++;
    if (cap_low != 68 || cap_sample !== 8'h81 || cap_src !== 1'b1) begin
      errors++; $display("FAIL t4_second_read: low=%0d sample=%h src=%b, required 68/81/1", cap_low, cap_sample, cap_src);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ovr_total - o0 != 1 || cs_n !== 1'b1) begin
      errors++; $display("FAIL t4_overrun: pulses=%0d cs_n=%b, required 1/1", ovr_total - o0, cs_n);
    end
  endtask

  task automatic test_en_abort();
    int v0;
    frame_word = 16'hFFFF;
    v0 = valid_total;
    pulse_trig();
    repeat (31) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      errors++; $display("FAIL t5_abort: cs_n=%b sck=%b busy=%b valid=%b, required 1/0/0/0", cs_n, sck, busy, sample_valid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (sample !== 8'h81 || sample_src !== 1'b1 || valid_total - v0 != 0) begin
      errors++; $display("FAIL t5_hold: sample=%h src=%b reads=%0d, required 81/1/0", sample, sample_src, valid_total - v0);
    end
    en = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_no_resume: cs_n=%b busy=%b, required 1/0", cs_n, busy);
    end
  endtask

  task automatic test_async_reset();
    frame_word = 16'h55AA;
    pulse_trig();
    repeat (66) @(negedge clk);
    checks++;
    if (cs_n !== 1'b0 || sck !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t6_in_hold: cs_n=%b sck=%b busy=%b, required 0/0/1", cs_n, sck, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || sck !== 1'b0 || sample !== 8'h00 || sample_src !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t6_async: cs_n=%b sck=%b sample=%h src=%b busy=%b, required 1/0/00/0/0",
                         cs_n, sck, sample, sample_src, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame_word = 16'h7E00;
    repeat (2) @(negedge clk);
    pulse_trig();
    capture(10);
    checks++;
    if (cap_found != 1 || cap_low != 68 || cap_pulses != 16 || cap_bad_high != 0) begin
      errors++; $display("FAIL t6_next_read: found=%0d low=%0d pulses=%0d bad_high=%0d, required 1/68/16/0",
                         cap_found, cap_low, cap_pulses, cap_bad_high);
    end
    checks++;
    if (cap_valid !== 1'b1 || cap_sample !== 8'h7E || cap_src !== 1'b1) begin
      errors++; $display("FAIL t6_sample: valid=%b sample=%h src=%b, required 1/7e/1", cap_valid, cap_sample, cap_src);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; auto_en = 1'b0; trig_req = 1'b0;
    test_reset();
    test_manual_read();
    test_auto_period();
    test_merge();
    test_back_to_back();
    test_en_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
